// File: rtl/bist_pkg.sv
// Shared types and constants for the JTAG-side BIST host.
// Build option BIST_HOST_USER_TEST_EN enables the USER test register.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int ovr_bit(input int stat_w);
        return stat_w + 1;
    endfunction

    function automatic int busy_bit(input int stat_w);
        return stat_w;
    endfunction

    function automatic int start_bit(input int conf_w);
        return conf_w;
    endfunction

    localparam state_t      STATE_RST = IDLE;
    localparam logic [15:0] CNT_RST   = 16'd0;
    localparam logic        OUT_RST   = 1'b0;

endpackage

// File: rtl/bist_jtag_host_if.sv
// TAP-side DR controls and BIST engine signals of the JTAG BIST host.
// Build option BIST_HOST_USER_TEST_EN enables the USER test register.
interface bist_jtag_host_if #(
    parameter int CONF_W = 13,
    parameter int USER_W = 2052,
    parameter int STAT_W = 16
);
    logic              TDI;
    logic              CAPTURE_DR;
    logic              SHIFT_DR;
    logic              UPDATE_DR;
    logic              SEL_CONF;
    logic              SEL_USER;
    logic              SEL_STATUS;
    logic [STAT_W-1:0] BIST_STATUS_REG;
    logic              TDO;
    logic [CONF_W-1:0] BIST_CONF_REG;
    logic [USER_W-1:0] BIST_USER_TEST;
    logic              ENABLE;
    logic              BUSY;

    modport master (
        output TDI, CAPTURE_DR, SHIFT_DR, UPDATE_DR,
        output SEL_CONF, SEL_USER, SEL_STATUS,
        output BIST_STATUS_REG,
        input  TDO, BIST_CONF_REG, BIST_USER_TEST, ENABLE, BUSY
    );

    modport slave (
        input  TDI, CAPTURE_DR, SHIFT_DR, UPDATE_DR,
        input  SEL_CONF, SEL_USER, SEL_STATUS,
        input  BIST_STATUS_REG,
        output TDO, BIST_CONF_REG, BIST_USER_TEST, ENABLE, BUSY
    );

endinterface

// File: rtl/jtag_dr_cell.sv
// Generic N-bit JTAG data register: shift register plus update shadow.
// Strobe priority is resolved by the caller; enables arrive mutually exclusive.
module jtag_dr_cell #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cap_en,
    input  logic         shift_en,
    input  logic         upd_en,
    input  logic         tdi,
    input  logic [N-1:0] cap_val,
    output logic [N-1:0] sr,
    output logic [N-1:0] q
);

    logic [N-1:0] nxt;

    // LSB leaves toward TDO, TDI enters at the MSB
    always_comb begin
        nxt = sr >> 1;
        nxt[N-1] = tdi;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (cap_en) begin
            sr <= cap_val;
        end else if (shift_en) begin
            sr <= nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (upd_en) begin
            q <= sr;
        end
    end

endmodule

// File: rtl/bist_jtag_host.sv
// JTAG DR host for the BIST engine: CONF/USER/STATUS DRs and run sequencer.
// Build option BIST_HOST_USER_TEST_EN enables the USER test register.
import bist_pkg::*;

module bist_jtag_host #(
    parameter int CONF_W     = 13,
    parameter int USER_W     = 2052,
    parameter int STAT_W     = 16,
    parameter int RUN_CYCLES = 4096
) (
    input logic              CLK,
    input logic              RST,
    bist_jtag_host_if.slave  bus
);

    localparam int CW      = CONF_W + 1;
    localparam int SW      = STAT_W + 2;
    localparam int START_B = start_bit(CONF_W);
    localparam int BUSY_B  = busy_bit(STAT_W);
    localparam int OVR_B   = ovr_bit(STAT_W);
    localparam logic [15:0] RUN_START = 16'(RUN_CYCLES - 1);

    logic sc, su, ss;
    logic cap, shf, upd;

    assign sc  = bus.SEL_CONF;
    assign su  = ~bus.SEL_CONF & bus.SEL_USER;
    assign ss  = ~bus.SEL_CONF & ~bus.SEL_USER & bus.SEL_STATUS;
    assign cap = bus.CAPTURE_DR;
    assign shf = bus.SHIFT_DR & ~bus.CAPTURE_DR;
    assign upd = bus.UPDATE_DR & ~bus.CAPTURE_DR & ~bus.SHIFT_DR;

    state_t            state;
    logic [15:0]       cnt;
    logic              enable;
    logic              busy;
    logic              ovr;
    logic [STAT_W-1:0] snap;
    logic              start;
    logic              user_ovr;

    logic [CW-1:0] conf_sr, conf_q, conf_cap;
    logic          unused_start_q;

    // the START bit is a one-shot trigger and always reads back as 0
    assign conf_cap       = {1'b0, conf_q[CONF_W-1:0]};
    assign unused_start_q = conf_q[START_B];
    assign start          = sc & upd & ~busy & conf_sr[START_B];

    jtag_dr_cell #(.N(CW)) u_conf (
        .clk      (CLK),
        .rst      (RST),
        .cap_en   (sc & cap),
        .shift_en (sc & shf),
        .upd_en   (sc & upd & ~busy),
        .tdi      (bus.TDI),
        .cap_val  (conf_cap),
        .sr       (conf_sr),
        .q        (conf_q)
    );

    assign bus.BIST_CONF_REG = conf_q[CONF_W-1:0];

`ifdef BIST_HOST_USER_TEST_EN
    logic [USER_W-1:0] user_sr, user_q;

    jtag_dr_cell #(.N(USER_W)) u_user (
        .clk      (CLK),
        .rst      (RST),
        .cap_en   (su & cap),
        .shift_en (su & shf),
        .upd_en   (su & upd & ~busy),
        .tdi      (bus.TDI),
        .cap_val  (user_q),
        .sr       (user_sr),
        .q        (user_q)
    );

    assign bus.BIST_USER_TEST = user_q;
    assign user_ovr           = su & upd & busy;
`else
    logic [0:0] user_sr;
    logic [0:0] unused_user_q;

    jtag_dr_cell #(.N(1)) u_user (
        .clk      (CLK),
        .rst      (RST),
        .cap_en   (su & cap),
        .shift_en (su & shf),
        .upd_en   (1'b0),
        .tdi      (bus.TDI),
        .cap_val  (1'b0),
        .sr       (user_sr),
        .q        (unused_user_q)
    );

    assign bus.BIST_USER_TEST = {USER_W{1'b0}};
    assign user_ovr           = 1'b0;
`endif

    logic [SW-1:0] stat_sr, stat_cap;
    logic [SW-1:0] unused_stat_q;

    always_comb begin
        stat_cap = '0;
        stat_cap[STAT_W-1:0] = snap;
        stat_cap[BUSY_B] = busy;
        stat_cap[OVR_B]  = ovr;
    end

    jtag_dr_cell #(.N(SW)) u_stat (
        .clk      (CLK),
        .rst      (RST),
        .cap_en   (ss & cap),
        .shift_en (ss & shf),
        .upd_en   (1'b0),
        .tdi      (bus.TDI),
        .cap_val  (stat_cap),
        .sr       (stat_sr),
        .q        (unused_stat_q)
    );

    always_comb begin
        bus.TDO = 1'b0;
        unique case (1'b1)
            sc:      bus.TDO = conf_sr[0];
            su:      bus.TDO = user_sr[0];
            ss:      bus.TDO = stat_sr[0];
            default: bus.TDO = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= STATE_RST;
            cnt    <= CNT_RST;
            enable <= OUT_RST;
            busy   <= OUT_RST;
            ovr    <= 1'b0;
            snap   <= '0;
        end else begin
            // a new overrun beats the clear from a simultaneous capture
            if ((sc & upd & busy) | user_ovr) begin
                ovr <= 1'b1;
            end else if (ss & cap) begin
                ovr <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        cnt    <= RUN_START;
                        enable <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                RUN: begin
                    if (cnt == 16'd0) begin
                        state  <= DONE;
                        enable <= 1'b0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                DONE: begin
                    snap  <= bus.BIST_STATUS_REG;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ENABLE = enable;
    assign bus.BUSY   = busy;

endmodule

// File: tb/tb_bist_jtag_host.sv
// Directed bench for bist_jtag_host: DR scans, run timing, overrun, reset.
// Expectations for USER follow BIST_HOST_USER_TEST_EN.
module tb_bist_jtag_host;

    localparam int CONF_W     = 13;
    localparam int USER_W     = 2052;
    localparam int STAT_W     = 16;
    localparam int RUN_CYCLES = 4096;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bist_jtag_host_if #(
        .CONF_W(CONF_W), .USER_W(USER_W), .STAT_W(STAT_W)
    ) bus ();

    bist_jtag_host #(
        .CONF_W(CONF_W), .USER_W(USER_W),
        .STAT_W(STAT_W), .RUN_CYCLES(RUN_CYCLES)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        bus.TDI        = 1'b0;
        bus.CAPTURE_DR = 1'b0;
        bus.SHIFT_DR   = 1'b0;
        bus.UPDATE_DR  = 1'b0;
        bus.SEL_CONF   = 1'b0;
        bus.SEL_USER   = 1'b0;
        bus.SEL_STATUS = 1'b0;
    endtask

    // sel: 0 CONF, 1 USER, 2 STATUS; returns in the cycle after the last edge
    task automatic scan(input int sel, input int n,
                        input logic [USER_W-1:0] din, input bit do_upd,
                        output logic [USER_W-1:0] dout);
        dout = '0;
        bus.SEL_CONF   = (sel == 0);
        bus.SEL_USER   = (sel == 1);
        bus.SEL_STATUS = (sel == 2);
        bus.CAPTURE_DR = 1'b1;
        tick();
        bus.CAPTURE_DR = 1'b0;
        bus.SHIFT_DR   = 1'b1;
        for (int i = 0; i < n; i++) begin
            dout[i] = bus.TDO;
            bus.TDI = din[i];
            tick();
        end
        bus.SHIFT_DR = 1'b0;
        bus.TDI      = 1'b0;
        if (do_upd) begin
            bus.UPDATE_DR = 1'b1;
            tick();
            bus.UPDATE_DR = 1'b0;
        end
        idle_in();
    endtask

    task automatic wait_run_end(output int n);
        n = 0;
        while (bus.ENABLE && n < 5000) begin
            n++;
            tick();
        end
    endtask

    logic [USER_W-1:0] rd, pat, exp_v, zero_v;
    int n;

    initial begin
        zero_v = '0;
        rst = 1'b1;
        idle_in();
        bus.BIST_STATUS_REG = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_en",   64'(bus.ENABLE), 64'd0);
        chk("rst_busy", 64'(bus.BUSY), 64'd0);
        chk("rst_tdo",  64'(bus.TDO), 64'd0);
        chk("rst_conf", 64'(bus.BIST_CONF_REG), 64'd0);
        chk("rst_user", 64'(bus.BIST_USER_TEST == zero_v), 64'd1);
        scan(2, 18, zero_v, 1'b0, rd);
        chk("rst_stat", 64'(rd[17:0]), 64'h0);

        // run 1: start, length, DONE snapshot
        bus.BIST_STATUS_REG = 16'h1234;
        scan(0, 14, USER_W'({1'b1, 13'h0A5}), 1'b1, rd);
        chk("r1_conf", 64'(bus.BIST_CONF_REG), 64'h0A5);
        chk("r1_en",   64'(bus.ENABLE), 64'd1);
        chk("r1_busy", 64'(bus.BUSY), 64'd1);
        wait_run_end(n);
        chk("r1_len",       64'(n), 64'd4096);
        chk("r1_done_en",   64'(bus.ENABLE), 64'd0);
        chk("r1_done_busy", 64'(bus.BUSY), 64'd1);
        bus.BIST_STATUS_REG = 16'hBEEF;
        tick();
        bus.BIST_STATUS_REG = 16'h1234;
        chk("r1_busy_fall", 64'(bus.BUSY), 64'd0);
        scan(2, 18, zero_v, 1'b1, rd);
        chk("r1_stat", 64'(rd[17:0]), 64'h0BEEF);
        scan(0, 14, zero_v, 1'b0, rd);
        chk("conf_rd", 64'(rd[13:0]), 64'h00A5);

        // run 2: updates while busy are dropped and flag OVERRUN
        scan(0, 14, USER_W'({1'b1, 13'h0C3}), 1'b1, rd);
        chk("r2_conf", 64'(bus.BIST_CONF_REG), 64'h0C3);
        scan(0, 14, USER_W'({1'b1, 13'h1FFF}), 1'b1, rd);
        chk("ovr_conf", 64'(bus.BIST_CONF_REG), 64'h0C3);
        chk("ovr_en",   64'(bus.ENABLE), 64'd1);
        scan(2, 18, zero_v, 1'b0, rd);
        chk("ovr_rd1", 64'(rd[17:0]), 64'h3BEEF);
        scan(1, 4, USER_W'(4'hF), 1'b1, rd);
        chk("ovr_user", 64'(bus.BIST_USER_TEST == zero_v), 64'd1);
        scan(2, 18, zero_v, 1'b0, rd);
`ifdef BIST_HOST_USER_TEST_EN
        chk("ovr_rd2", 64'(rd[17:0]), 64'h3BEEF);
`else
        chk("ovr_rd2", 64'(rd[17:0]), 64'h1BEEF);
`endif
        wait_run_end(n);
        chk("r2_end", 64'(bus.ENABLE), 64'd0);
        // capture in the DONE cycle sees BUSY and the previous SNAP
        bus.BIST_STATUS_REG = 16'h5A5A;
        scan(2, 18, zero_v, 1'b0, rd);
        bus.BIST_STATUS_REG = 16'h0000;
        chk("done_cap", 64'(rd[17:0]), 64'h1BEEF);
        scan(2, 18, zero_v, 1'b0, rd);
        chk("snap2", 64'(rd[17:0]), 64'h05A5A);

        // USER register, pattern 0xA repeated
        for (int i = 0; i < USER_W; i++) pat[i] = (i % 2 == 1);
        scan(1, USER_W, pat, 1'b1, rd);
`ifdef BIST_HOST_USER_TEST_EN
        chk("user_rd1", 64'(rd == zero_v), 64'd1);
        chk("user_q1",  64'(bus.BIST_USER_TEST == pat), 64'd1);
`else
        exp_v = {pat[USER_W-2:0], 1'b0};
        chk("user_rd1", 64'(rd == exp_v), 64'd1);
        chk("user_q1",  64'(bus.BIST_USER_TEST == zero_v), 64'd1);
`endif
        scan(1, USER_W, ~pat, 1'b1, rd);
`ifdef BIST_HOST_USER_TEST_EN
        exp_v = ~pat;
        chk("user_rd2", 64'(rd == pat), 64'd1);
        chk("user_q2",  64'(bus.BIST_USER_TEST == exp_v), 64'd1);
`else
        exp_v = {~pat[USER_W-2:0], 1'b0};
        chk("user_rd2", 64'(rd == exp_v), 64'd1);
        chk("user_q2",  64'(bus.BIST_USER_TEST == zero_v), 64'd1);
`endif
        chk("user_no_run", 64'(bus.ENABLE), 64'd0);

        // reset in the middle of a run
        bus.BIST_STATUS_REG = 16'hFFFF;
        scan(0, 14, USER_W'({1'b1, 13'h123}), 1'b1, rd);
        chk("r3_en", 64'(bus.ENABLE), 64'd1);
        repeat (99) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_en",   64'(bus.ENABLE), 64'd0);
        chk("mrst_busy", 64'(bus.BUSY), 64'd0);
        chk("mrst_conf", 64'(bus.BIST_CONF_REG), 64'd0);
        chk("mrst_user", 64'(bus.BIST_USER_TEST == zero_v), 64'd1);
        chk("mrst_tdo",  64'(bus.TDO), 64'd0);
        repeat (10) tick();
        chk("mrst_en2", 64'(bus.ENABLE), 64'd0);
        scan(2, 18, zero_v, 1'b0, rd);
        chk("mrst_stat", 64'(rd[17:0]), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bist_jtag_host.md
# bist_jtag_host

JTAG-side host for the BIST engine: owns the test data registers through which a TAP controller programs the BIST configuration, loads the user test vector, starts a run and reads back the result. It generates the `BIST_CONF_REG`, `BIST_USER_TEST` and `ENABLE` inputs consumed by `bist_test_module`, and samples its `BIST_STATUS_REG` output. It sits between the TAP controller's DR-state decode and the BIST wrapper.

## Interface
- `CONF_W`, default 13: width of `BIST_CONF_REG`.
- `USER_W`, default 2052: width of `BIST_USER_TEST`.
- `STAT_W`, default 16: width of `BIST_STATUS_REG`.
- `RUN_CYCLES`, default 4096: cycles `ENABLE` is held per run; 1 to 65535.
- `CLK` input 1: single clock, shared with the TAP decode and the BIST engine.
- `RST` input 1: reset, synchronous and active-high.
- `TDI` input 1: serial data in.
- `CAPTURE_DR` input 1: one-cycle capture strobe.
- `SHIFT_DR` input 1: shift enable, one bit per cycle.
- `UPDATE_DR` input 1: one-cycle update strobe.
- `SEL_CONF` input 1: instruction selects CONF DR.
- `SEL_USER` input 1: instruction selects USER DR.
- `SEL_STATUS` input 1: instruction selects STATUS DR.
- `BIST_STATUS_REG` input STAT_W: result from the BIST engine.
- `TDO` output 1: serial data out.
- `BIST_CONF_REG` output CONF_W: configuration to the BIST engine.
- `BIST_USER_TEST` output USER_W: user test vector to the BIST engine.
- `ENABLE` output 1: BIST run enable.
- `BUSY` output 1: run in progress.

## Operation
- Three DRs, each a shift register plus a shadow register:
  - CONF: CONF_W+1 bits, `{START, CONF}`.
  - USER: USER_W bits.
  - STATUS: STAT_W+2 bits, `{OVERRUN, BUSY, SNAP}`. Read-only; update is a no-op.
- Select priority: CONF > USER > STATUS. With no select asserted, `TDO`=0 and strobes are ignored.
- Capture: the selected shift register loads its shadow. For STATUS it loads `{OVERRUN, BUSY, SNAP}`, and CONF capture returns START=0.
- Shift: `sr <= {TDI, sr[N-1:1]}`, with `TDO = sr[0]` combinationally. Data enters and leaves LSB first.
- Strobe collisions: if more than one of CAPTURE/SHIFT/UPDATE is asserted, capture wins over shift and shift wins over update.
- Update when idle:
  - CONF: `BIST_CONF_REG` <= shifted CONF. If START=1, enter RUN.
  - USER: `BIST_USER_TEST` <= shifted vector.
- Update while BUSY: the update is discarded, outputs are unchanged, and OVERRUN is set. OVERRUN is sticky and is cleared only by a STATUS capture, after that capture has sampled it.
- State machine IDLE -> RUN -> DONE -> IDLE:
  - IDLE: `ENABLE`=0, `BUSY`=0.
  - RUN: `ENABLE`=1 and `BUSY`=1, while a 16-bit counter counts RUN_CYCLES-1 down to 0.
  - DONE: one cycle with `ENABLE`=0 and `BUSY`=1. `SNAP` <= `BIST_STATUS_REG`, then return to IDLE.
- `BIST_CONF_REG`/`BIST_USER_TEST` are never changed while `ENABLE`=1.

## Timing
- Reset values: `TDO`=0, `BIST_CONF_REG`=0, `BIST_USER_TEST`=0, `ENABLE`=0, `BUSY`=0. SNAP, OVERRUN, all shift registers and the counter are 0; the state is IDLE.
- Start latency: `UPDATE_DR` in cycle t puts the new `BIST_CONF_REG` and `ENABLE`=1 in cycle t+1, together.
- Run length: `ENABLE` is high for exactly RUN_CYCLES cycles, t+1 .. t+RUN_CYCLES.
- Snapshot: taken in cycle t+RUN_CYCLES+1 (DONE). `BUSY` falls at t+RUN_CYCLES+2.
- STATUS capture in the DONE cycle returns BUSY=1 and the old SNAP.
- `TDO` changes in the cycle after each capture or shift edge.
- `RST` mid-run: in the next cycle `ENABLE`=0, all registers are at their reset values and the partial result is discarded.

## Configuration
- `BIST_HOST_USER_TEST_EN` defined: the USER DR and `BIST_USER_TEST` register are built as described.
- `BIST_HOST_USER_TEST_EN` undefined:
  - `BIST_USER_TEST` is tied to 0.
  - `SEL_USER` selects a 1-bit bypass register, which captures 0 and performs no update.
  - OVERRUN is never set by USER updates.

## Structure
- Shared package `bist_pkg`:
  - state encoding `IDLE`/`RUN`/`DONE`;
  - STATUS bit positions: OVERRUN = STAT_W+1, BUSY = STAT_W;
  - START bit index = CONF_W;
  - reset-value constants.
- One sub-module `jtag_dr_cell`: a generic N-bit capture/shift/update register with parameter N.
  - Instantiated for CONF, USER (or bypass) and STATUS.
  - The run FSM and OVERRUN logic stay in `bist_jtag_host`.

## Test plan
- Reset then STATUS scan of 18 bits -> `TDO` stream is all 0; `ENABLE`=0, `BUSY`=0.
- Shift CONF `{1, 13'h0A5}`, then update at t -> `BIST_CONF_REG`=13'h0A5 and `ENABLE`=1 at t+1; `ENABLE` falls after exactly 4096 cycles; `BUSY` falls at t+4098.
- Drive `BIST_STATUS_REG`=16'hBEEF during the DONE cycle, then STATUS scan -> read value 18'h0BEEF, LSB first.
- CONF update with START=1 issued mid-run -> `BIST_CONF_REG` is unchanged. The next STATUS read shows OVERRUN=1; the read after that shows OVERRUN=0.
- USER scan of 2052 bits with pattern 0xA repeated, then update -> `BIST_USER_TEST` matches. Build without the macro -> output stays 0 and the USER scan shows a 1-bit delay.
- `RST` asserted at run cycle 100 -> `ENABLE`=0 in the next cycle, all outputs at reset values, and SNAP is not updated.
